// File: rtl/shift_unit_if.sv
// ----------------------------------------------------------------------------
// shift_unit_if
// Start/done request bus between the control sequencer (master) and the
// multi-cycle shift unit (slave).
//   start     : request, sampled by the unit only when it is idle or done
//   mode      : 000 shr, 001 shra, 010 shl, 011 ror, 100 rol (others illegal)
//   operand   : value to shift, sampled with start
//   shamt     : shift amount, sampled with start, reduced modulo WIDTH
//   busy      : unit is shifting
//   done      : one-cycle completion pulse
//   result    : working register, valid from done until the next accept
//   carry_out : last bit shifted/rotated out (only with SHIFT_CARRY_EN)
// Optional feature macro: SHIFT_CARRY_EN
// ----------------------------------------------------------------------------
interface shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 6
);
    logic               start;
    logic [2:0]         mode;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
`ifdef SHIFT_CARRY_EN
    logic               carry_out;

    modport master (output start, mode, operand, shamt,
                    input  busy, done, result, carry_out);
    modport slave  (input  start, mode, operand, shamt,
                    output busy, done, result, carry_out);
`else
    modport master (output start, mode, operand, shamt,
                    input  busy, done, result);
    modport slave  (input  start, mode, operand, shamt,
                    output busy, done, result);
`endif
endinterface

// File: rtl/shift_unit.sv
// ----------------------------------------------------------------------------
// shift_unit
// Multi-cycle shift/rotate unit: shifts the latched operand by STEP bits per
// clock (the last step may be shorter) under a start/done handshake.
// Ports:
//   i_clock : rising-edge clock
//   i_clear : synchronous active-high reset, wins over everything
//   bus     : shift_unit_if.slave (start, mode, operand, shamt, busy, done,
//             result and, with SHIFT_CARRY_EN, carry_out)
// Parameters: WIDTH (power of two, 8..64), STEP (power of two, 1..WIDTH),
//             SHAMT_W (>= log2(WIDTH)).
// Optional feature macro: SHIFT_CARRY_EN adds the carry_out register.
// ----------------------------------------------------------------------------
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = 6
) (
    input  logic        i_clock,
    input  logic        i_clear,
    shift_unit_if.slave bus
);
    localparam int RW = $clog2(WIDTH);
    // Remaining count never exceeds WIDTH-1, so a STEP of WIDTH behaves
    // exactly like WIDTH-1 and the clamped value fits in RW bits.
    localparam int STEP_C = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
    localparam logic [RW-1:0] STEP_V = RW'(STEP_C);

    localparam logic [2:0] M_SHR  = 3'b000;
    localparam logic [2:0] M_SHRA = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_result, w_shifted;
    logic [RW-1:0]    r_rem, w_step, w_k, w_lo_idx, w_hi_idx;
    logic [2:0]       r_mode;
    logic             r_sign;
    logic             w_accept, w_go_shift, w_last;
    logic [2*WIDTH-1:0] w_wide;

    // shamt is reduced modulo WIDTH by keeping only its low RW bits.
    assign w_k        = bus.shamt[RW-1:0];
    assign w_accept   = (r_state != S_SHIFT) && bus.start;
    assign w_go_shift = (w_k != '0) && (bus.mode <= M_ROL);
    assign w_step     = (r_rem < STEP_V) ? r_rem : STEP_V;
    assign w_last     = (r_rem == w_step);
    // Index of the last bit leaving the register on this step: bit s-1 for
    // right moves, bit WIDTH-s for left moves (WIDTH wraps to 0 in RW bits).
    assign w_lo_idx   = w_step - RW'(1);
    assign w_hi_idx   = RW'(0) - w_step;

    generate
        if (SHAMT_W > RW) begin : g_shamt_hi
            logic w_unused_shamt;
            assign w_unused_shamt = ^bus.shamt[SHAMT_W-1:RW];
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset here is synchronous to i_clock.
    always_ff @(posedge i_clock) begin
        if (i_clear) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned,
        // which would otherwise infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) w_next = w_go_shift ? S_SHIFT : S_DONE;
                else           w_next = S_IDLE;
            end
            S_SHIFT: if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from the state register) -------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_SHIFT: bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath: one step of the latched mode ----------------
    always_comb begin
        w_wide    = '0;
        w_shifted = r_result;
        case (r_mode)
            M_SHR:  w_shifted = r_result >> w_step;
            M_SHRA: begin
                // Sign word on top supplies the fill bits latched at accept.
                w_wide    = {{WIDTH{r_sign}}, r_result} >> w_step;
                w_shifted = w_wide[WIDTH-1:0];
            end
            M_SHL:  w_shifted = r_result << w_step;
            M_ROR: begin
                w_wide    = {r_result, r_result} >> w_step;
                w_shifted = w_wide[WIDTH-1:0];
            end
            M_ROL: begin
                w_wide    = {r_result, r_result} << w_step;
                w_shifted = w_wide[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_result <= '0;
            r_rem    <= '0;
            r_mode   <= '0;
            r_sign   <= 1'b0;
        end else if (w_accept) begin
            r_result <= bus.operand;
            r_rem    <= w_k;
            r_mode   <= bus.mode;
            r_sign   <= bus.operand[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_result <= w_shifted;
            r_rem    <= r_rem - w_step;
        end
    end

    assign bus.result = r_result;

`ifdef SHIFT_CARRY_EN
    logic r_carry, w_carry;

    always_comb begin
        case (r_mode)
            M_SHL, M_ROL: w_carry = r_result[w_hi_idx];
            default:      w_carry = r_result[w_lo_idx];
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear)                  r_carry <= 1'b0;
        else if (w_accept)            r_carry <= 1'b0;
        else if (r_state == S_SHIFT)  r_carry <= w_carry;
    end

    assign bus.carry_out = r_carry;
`else
    logic w_unused_idx;
    assign w_unused_idx = ^{w_lo_idx, w_hi_idx};
`endif

endmodule

// File: tb/tb_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_shift_unit
// Two shift_unit instances (STEP=1 and STEP=4) driven by directed and random
// requests. Each request pushes its expected result, carry and timing into a
// per-instance queue; a monitor pops and compares whenever done is seen.
// Optional feature macro: SHIFT_CARRY_EN (carry_out also checked).
// ----------------------------------------------------------------------------
module tb_shift_unit;
    typedef struct {
        logic [31:0] res;
        logic        carry;
        int          n;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        t_clear [2];
    logic        t_start [2];
    logic [2:0]  t_mode  [2];
    logic [31:0] t_op    [2];
    logic [5:0]  t_sh    [2];
    logic        t_busy  [2];
    logic        t_done  [2];
    logic [31:0] t_res   [2];
    logic        t_carry [2];

    exp_t sb [2][$];
    int   bcnt [2];
    int   steps [2] = '{1, 4};

    shift_unit_if #(.WIDTH(32), .SHAMT_W(6)) u_if0 ();
    shift_unit_if #(.WIDTH(32), .SHAMT_W(6)) u_if1 ();

    shift_unit #(.WIDTH(32), .STEP(1), .SHAMT_W(6)) u_dut0 (
        .i_clock(clk), .i_clear(t_clear[0]), .bus(u_if0.slave));
    shift_unit #(.WIDTH(32), .STEP(4), .SHAMT_W(6)) u_dut1 (
        .i_clock(clk), .i_clear(t_clear[1]), .bus(u_if1.slave));

    assign u_if0.start = t_start[0];  assign u_if1.start = t_start[1];
    assign u_if0.mode = t_mode[0];    assign u_if1.mode = t_mode[1];
    assign u_if0.operand = t_op[0];   assign u_if1.operand = t_op[1];
    assign u_if0.shamt = t_sh[0];     assign u_if1.shamt = t_sh[1];
    assign t_busy[0] = u_if0.busy;    assign t_busy[1] = u_if1.busy;
    assign t_done[0] = u_if0.done;    assign t_done[1] = u_if1.done;
    assign t_res[0] = u_if0.result;   assign t_res[1] = u_if1.result;
`ifdef SHIFT_CARRY_EN
    assign t_carry[0] = u_if0.carry_out;
    assign t_carry[1] = u_if1.carry_out;
`else
    assign t_carry[0] = 1'b0;
    assign t_carry[1] = 1'b0;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the whole shift done at once with plain operators.
    function automatic exp_t model(input logic [2:0] m, input logic [31:0] op,
                                   input logic [5:0] sh, input int step);
        exp_t e;
        int k;
        k       = int'(sh) % 32;
        e.res   = op;
        e.carry = 1'b0;
        e.n     = 0;
        e.cyc   = 0;
        if (m <= 3'd4 && k != 0) begin
            e.n = (k + step - 1) / step;
            case (m)
                3'd0: begin e.res = op >> k;                         e.carry = op[k-1];  end
                3'd1: begin e.res = 32'($signed(op) >>> k);          e.carry = op[k-1];  end
                3'd2: begin e.res = op << k;                         e.carry = op[32-k]; end
                3'd3: begin e.res = (op >> k) | (op << (32 - k));    e.carry = op[k-1];  end
                default: begin e.res = (op << k) | (op >> (32 - k)); e.carry = op[32-k]; end
            endcase
        end
        return e;
    endfunction

    // Monitor: compare every done pulse with the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (t_clear[d]) begin
                bcnt[d] = 0;
            end else begin
                if (t_busy[d]) bcnt[d]++;
                if (t_done[d]) begin
                    if (sb[d].size() == 0) begin
                        check($sformatf("dut%0d unexpected_done", d), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        check($sformatf("dut%0d result", d), t_res[d], e.res);
`ifdef SHIFT_CARRY_EN
                        check($sformatf("dut%0d carry", d), t_carry[d], e.carry);
`endif
                        check($sformatf("dut%0d latency", d), cyc - e.cyc, e.n + 1);
                        check($sformatf("dut%0d busy_cycles", d), bcnt[d], e.n);
                    end
                    bcnt[d] = 0;
                end
            end
        end
    end

    task automatic present(input int d, input logic [2:0] m, input logic [31:0] op,
                           input logic [5:0] sh);
        exp_t e;
        t_mode[d]  = m;
        t_op[d]    = op;
        t_sh[d]    = sh;
        t_start[d] = 1'b1;
        e     = model(m, op, sh, steps[d]);
        e.cyc = cyc;
        sb[d].push_back(e);
    endtask

    task automatic issue(input int d, input logic [2:0] m, input logic [31:0] op,
                         input logic [5:0] sh);
        @(posedge clk); #1;
        present(d, m, op, sh);
        @(posedge clk); #1;
        t_start[d] = 1'b0;
        t_op[d]    = $urandom;   // later changes must not matter
        t_sh[d]    = 6'($urandom);
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb[d].size() == 0) break;
        end
        check($sformatf("dut%0d drain", d), sb[d].size(), 0);
        sb[d].delete();
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("dut%0d %s busy", d, tag), t_busy[d], 0);
        check($sformatf("dut%0d %s done", d, tag), t_done[d], 0);
        check($sformatf("dut%0d %s result", d, tag), t_res[d], 0);
`ifdef SHIFT_CARRY_EN
        check($sformatf("dut%0d %s carry", d, tag), t_carry[d], 0);
`endif
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_clear[d] = 1'b1; t_start[d] = 1'b0;
            t_mode[d] = '0; t_op[d] = '0; t_sh[d] = '0; bcnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        t_clear[0] = 1'b0; t_clear[1] = 1'b0;

        // Directed cases, STEP=1
        issue(0, 3'b001, 32'h8000_0010, 6'd4);  wait_idle(0);
        issue(0, 3'b000, 32'h8000_0010, 6'd4);  wait_idle(0);
        issue(0, 3'b100, 32'h8000_0001, 6'd33); wait_idle(0);
        issue(0, 3'b011, 32'h0000_0001, 6'd31); wait_idle(0);
        issue(0, 3'b010, 32'h0000_0001, 6'd32); wait_idle(0);

        // Directed cases, STEP=4
        issue(1, 3'b010, 32'h0000_000F, 6'd7);  wait_idle(1);
        issue(1, 3'b010, 32'h0000_000F, 6'd0);  wait_idle(1);
        issue(1, 3'b001, 32'h8000_0000, 6'd31); wait_idle(1);

        // start pulsed mid-SHIFT is ignored
        issue(0, 3'b011, 32'hDEAD_BEEF, 6'd9);
        @(posedge clk); #1;
        t_start[0] = 1'b1; t_mode[0] = 3'b000; t_op[0] = 32'h0; t_sh[0] = 6'd1;
        @(posedge clk); #1;
        t_start[0] = 1'b0;
        wait_idle(0);

        // clear in SHIFT abandons the operation, no done afterwards
        issue(0, 3'b010, 32'hFFFF_FFFF, 6'd20);
        @(posedge clk); #1;
        t_clear[0] = 1'b1;
        @(posedge clk); #1;
        t_clear[0] = 1'b0;
        sb[0].delete();
        check_zero(0, "clear");
        repeat (30) @(posedge clk);
        issue(0, 3'b001, 32'h8765_4321, 6'd8);  wait_idle(0);

        // Illegal mode then back-to-back accept with start held across DONE
        @(posedge clk); #1;
        present(0, 3'b110, 32'h1234_5678, 6'd5);
        @(posedge clk); #1;
        present(0, 3'b011, 32'hA5A5_0F0F, 6'd5);
        @(posedge clk); #1;
        t_start[0] = 1'b0;
        wait_idle(0);

        // Back-to-back on the STEP=4 unit: shl of 0 then a long rotate
        @(posedge clk); #1;
        present(1, 3'b010, 32'h0000_00FF, 6'd0);
        @(posedge clk); #1;
        present(1, 3'b100, 32'hC000_0003, 6'd30);
        @(posedge clk); #1;
        t_start[1] = 1'b0;
        wait_idle(1);

        // Randomized requests on both units
        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < 2; d++) begin
                issue(d, 3'($urandom_range(0, 7)), $urandom, 6'($urandom_range(0, 63)));
                wait_idle(d);
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
